rf_stream_sequencer: RTL

- Sequential successor to the combinational receptive-field selector in the convolution front end.
- Walks a whole D×H×W image and emits every F×F×D receptive field needed by a convolution layer.
- Emits P windows per beat over a valid/ready handshake, with configurable stride and lane count, so the conv-unit array no longer needs an external row/column driver.
- Sits between the image buffer and the parallel conv units.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/rf_window_extract.sv | 55 +++++
 rtl/rf_stream_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution front end.
//   out_dim  : output extent of a convolution along one axis
//   ceil_div : integer ceiling division
//   fsm_state_t : frame sequencer state encoding
//   COORD_W  : width of signed window-origin coordinates
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Wide enough for any origin of a practical image, including negative
  // origins produced by a padding border.
  localparam int COORD_W = 16;

  function automatic int out_dim(input int size, input int f, input int s, input int pad);
    return (size + 2 * pad - f) / s + 1;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/rf_window_extract.sv
// Combinational extraction of one F x F x D receptive field.
// Ports:
//   image  : flat image, pixel (k,r,c) at element k*H*W + r*W + c, element 0 at bit 0
//   row0   : signed input row of the window's top-left pixel
//   col0   : signed input column of the window's top-left pixel
//   en     : lane carries a real window; when low the window is all zero
//   window : depth-major, then filter row, then filter column; element 0 at bit 0
// Build option ZERO_PAD_EN: pixels outside the image are driven as zero.
module rf_window_extract
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic [D*H*W*DATA_WIDTH-1:0] image,
  input  logic signed [COORD_W-1:0]   row0,
  input  logic signed [COORD_W-1:0]   col0,
  input  logic                        en,
  output logic [D*F*F*DATA_WIDTH-1:0] window
);

  // Gather every window pixel from the flat image.
  always_comb begin
    int   rr_s;
    int   cc_s;
    logic inb_s;
    rr_s   = 0;
    cc_s   = 0;
    inb_s  = 1'b0;
    window = '0;
    for (int k = 0; k < D; k++) begin
      for (int fr = 0; fr < F; fr++) begin
        for (int fc = 0; fc < F; fc++) begin
          rr_s = int'(row0) + fr;
          cc_s = int'(col0) + fc;
`ifdef ZERO_PAD_EN
          inb_s = (rr_s >= 0) && (rr_s < H) && (cc_s >= 0) && (cc_s < W);
`else
          inb_s = 1'b1;
`endif
          if (en && inb_s) begin
            window[((k*F + fr)*F + fc)*DATA_WIDTH +: DATA_WIDTH] =
              image[(k*H*W + rr_s*W + cc_s)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            window[((k*F + fr)*F + fc)*DATA_WIDTH +: DATA_WIDTH] = '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rf_stream_sequencer.sv
// Walks a D x H x W image and streams every F x F x D receptive field of a
// convolution layer, P windows per beat, over a valid/ready handshake.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   start           : one-cycle frame start request (ignored while busy)
//   image           : flat image, must stay stable from start to frame_done
//   busy            : frame in progress (low in the frame_done cycle)
//   rf_valid        : beat valid; held until accepted
//   rf_ready        : consumer accepts the beat
//   receptive_field : P windows, lane-major, element 0 at bit 0
//   lane_mask       : bit i set when lane i carries a real window
//   out_row/out_col : output row of the beat / output column of lane 0
//   frame_done      : one-cycle pulse after the last beat is accepted
// Build option ZERO_PAD_EN: honour PAD as a zero border around the image.
module rf_stream_sequencer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int S          = 1,
  parameter int P          = 14,
  parameter int PAD        = 0,
`ifdef ZERO_PAD_EN
  localparam int PADE      = PAD,
`else
  // PAD has no effect without padding support.
  localparam int PADE      = 0 * PAD,
`endif
  localparam int OUT_H     = out_dim(H, F, S, PADE),
  localparam int OUT_W     = out_dim(W, F, S, PADE),
  localparam int ROW_W     = $clog2(OUT_H) + 1,
  localparam int COL_W     = $clog2(OUT_W) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [D*H*W*DATA_WIDTH-1:0]   image,
  output logic                          busy,
  output logic                          rf_valid,
  input  logic                          rf_ready,
  output logic [P*D*F*F*DATA_WIDTH-1:0] receptive_field,
  output logic [P-1:0]                  lane_mask,
  output logic [ROW_W-1:0]              out_row,
  output logic [COL_W-1:0]              out_col,
  output logic                          frame_done
);

  localparam int BEATS  = ceil_div(OUT_W, P);
  localparam int BEAT_W = $clog2(BEATS) + 1;
  localparam int WIN_W  = D * F * F * DATA_WIDTH;

  fsm_state_t                state_r;
  logic [ROW_W-1:0]          row_r;
  logic [BEAT_W-1:0]         beat_r;

  logic                      accept_s;
  logic                      last_s;
  logic                      load_s;
  logic [ROW_W-1:0]          nrow_s;
  logic [BEAT_W-1:0]         nbeat_s;
  logic signed [COORD_W-1:0] row0_s;
  logic signed [COORD_W-1:0] col0_s [P];
  logic [P-1:0]              lane_en_s;
  logic [P*WIN_W-1:0]        rf_s;

  assign accept_s = rf_valid & rf_ready;
  assign last_s   = (row_r == ROW_W'(OUT_H - 1)) && (beat_r == BEAT_W'(BEATS - 1));

  // Select which beat (if any) is loaded into the output register at the next edge.
  always_comb begin
    load_s  = 1'b0;
    nrow_s  = row_r;
    nbeat_s = beat_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          nrow_s  = '0;
          nbeat_s = '0;
        end else begin
          load_s  = 1'b0;
        end
      end
      EMIT: begin
        if (accept_s && !last_s) begin
          load_s = 1'b1;
          if (beat_r == BEAT_W'(BEATS - 1)) begin
            nbeat_s = '0;
            nrow_s  = row_r + ROW_W'(1);
          end else begin
            nbeat_s = beat_r + BEAT_W'(1);
            nrow_s  = row_r;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Window origins and real-lane flags of the beat being loaded.
  always_comb begin
    row0_s = COORD_W'(int'(nrow_s) * S - PADE);
    for (int i = 0; i < P; i++) begin
      col0_s[i]    = COORD_W'((int'(nbeat_s) * P + i) * S - PADE);
      lane_en_s[i] = ((int'(nbeat_s) * P + i) < OUT_W);
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    rf_window_extract #(
      .DATA_WIDTH (DATA_WIDTH),
      .D          (D),
      .H          (H),
      .W          (W),
      .F          (F)
    ) u_win (
      .image  (image),
      .row0   (row0_s),
      .col0   (col0_s[i]),
      .en     (lane_en_s[i]),
      .window (rf_s[i*WIN_W +: WIN_W])
    );
  end

  // Frame FSM with registered handshake, status and beat outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      row_r           <= '0;
      beat_r          <= '0;
      busy            <= 1'b0;
      rf_valid        <= 1'b0;
      frame_done      <= 1'b0;
      receptive_field <= '0;
      lane_mask       <= '0;
      out_row         <= '0;
      out_col         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            state_r  <= EMIT;
            busy     <= 1'b1;
            rf_valid <= 1'b1;
          end else begin
            state_r  <= IDLE;
          end
        end
        EMIT: begin
          frame_done <= 1'b0;
          if (accept_s && last_s) begin
            state_r    <= DONE;
            busy       <= 1'b0;
            rf_valid   <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            state_r    <= EMIT;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          rf_valid   <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase

      // The next beat is sampled from the image in the same edge that accepts the previous one.
      if (load_s) begin
        row_r           <= nrow_s;
        beat_r          <= nbeat_s;
        receptive_field <= rf_s;
        lane_mask       <= lane_en_s;
        out_row         <= nrow_s;
        out_col         <= COL_W'(int'(nbeat_s) * P);
      end else begin
        row_r           <= row_r;
        beat_r          <= beat_r;
      end
    end
  end

endmodule
